gcd_sched: RTL and testbench
============================

Name: gcd_sched

Overview:
- Shares one gcd_top engine among N_REQ requesters.
- Arbitrates round-robin and captures the winner's operand pair.
- Drives the engine's serial load protocol (start, then A, then B), waits for done, and returns the result tagged with the requester ID.
- Restarts the engine after every job by pulsing its active-high reset, because the engine's DONE state is terminal. Handles zero operands itself, because the engine never terminates when either operand is 0.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- W, 16, operand/result width; must match the engine data width.
- IDW, $clog2(N_REQ), requester ID width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  level request per requester; held until gnt, operands stable while high.
- opa  in  N_REQ*W  operand A per requester, slice i = opa[i*W +: W].
- opb  in  N_REQ*W  operand B per requester, same slicing.
- gnt  out  N_REQ  one-hot, one-cycle pulse; operands captured this cycle.
- rsp_valid  out  1  result valid; held until rsp_ready.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  requester index of the result.
- rsp_gcd  out  W  gcd result.
- busy  out  1  high in every state except IDLE.
- eng_rst  out  1  active-high engine reset, from a dedicated flop.
- eng_start  out  1  engine start.
- eng_data  out  W  engine data_in.
- eng_done  in  1  engine done.
- eng_a  in  W  engine register A (holds the result when done).

Behaviour:
- Reset values:
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_gcd=0, busy=0.
  - eng_start=0, eng_data=0, eng_rst=1.
  - State IDLE; RR pointer set so requester 0 has top priority.
- eng_rst is 1 for the first clk after rst_n rises, then 0.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, CLEAR, RESP.
- IDLE, any req:
  - Grant the first set req searching from (last winner+1) mod N_REQ; pulse gnt[i].
  - Latch opa[i], opb[i] and i; update the pointer.
  - If latched A==0 or B==0: rsp_gcd <= A|B (0 when both are 0), go to RESP. The engine is not touched.
  - Otherwise go to START.
- START: eng_start=1 → LOAD_A.
- LOAD_A: eng_data=A → LOAD_B.
- LOAD_B: eng_data=B → WAIT.
- eng_data is 0 outside LOAD_A/LOAD_B.
- WAIT: hold until eng_done=1, then rsp_gcd <= eng_a → CLEAR. No timeout is needed: the engine always terminates for nonzero inputs.
- CLEAR: eng_rst=1 for exactly this cycle → RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_gcd are stable.
  - On rsp_valid & rsp_ready → IDLE.
  - No new grant is issued in the cycle rsp_ready is seen; earliest next gnt is the following cycle.
- Latency, measured as gnt cycle = 0 to first rsp_valid cycle:
  - Zero operand: 1.
  - Equal nonzero operands: 7.
  - General case: 7 + 2×(engine subtract iterations).
- rsp_ready held high: the response lasts exactly one cycle.
- A req dropped before its grant is simply not served. A req that stays high after its gnt is treated as a new request.
- Simultaneous requests: exactly one gnt per job. Requesters are served strictly in round-robin order, so no requester starves.
- rst_n low mid-job:
  - Job discarded, no response; eng_rst asserts immediately (asynchronous).
  - Requesters still holding req are re-arbitrated after reset.
- Arithmetic: no arithmetic in this block beyond A|B in the bypass path.

Decomposition:
- Shared package gcd_pkg: state enum type, default W=16.
- One sub-module gcd_rr_arb:
  - Parameter N_REQ; inputs req and en; outputs one-hot gnt and binary idx.
  - Contains the pointer flop; pointer updates only when en & |req.

Test Plan:
- Single job: req[0], opa=12, opb=8 → gnt[0] at cycle 0, eng_start at 1, eng_data 12 at 2 then 8 at 3, rsp_valid at 11 with rsp_gcd=4, rsp_id=0; eng_rst pulse at 10.
- Zero bypass: (0,9) → rsp_gcd=9 at cycle 1, eng_start never asserted. (0,0) → rsp_gcd=0.
- Contention: req=4'b1111 all held, rsp_ready=1 → grant order 0,1,2,3,0. Then (a,b)=(48,18) → 6; (17,5) → 1; (65535,65535) → 65535 at latency 7; (65535,1) → 1.
- Backpressure: rsp_ready=0 for 20 cycles → rsp_valid/rsp_id/rsp_gcd held stable, no gnt; one cycle after rsp_ready=1 the next grant occurs.
- Reset mid-job: drop rst_n during WAIT → eng_rst=1 at once, no rsp_valid. After release, req[2] still high → gnt[2] and the correct result.
- Back-to-back on one requester: req[1] held with changing operands → each job's result matches the operands latched at its own gnt.

Source files
------------

// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gcd_pkg
// Purpose : Shared types and defaults for the gcd_sched block (scheduler
//           FSM state encoding, default engine data width).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package gcd_pkg;

  // Default operand/result width; must match the shared gcd_top engine.
  localparam int GCD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_WAIT   = 3'd4,
    S_CLEAR  = 3'd5,
    S_RESP   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : gcd_sched_if
// Purpose : Bundles the requester, response and engine-side signals of the
//           gcd_sched block.
// Ports   : req/opa/opb/gnt     - requester handshake and operands
//           rsp_*               - tagged result towards the consumer
//           busy                - scheduler not idle
//           eng_*               - serial load protocol to the gcd_top engine
//           modport slave  : scheduler view
//           modport master : system / environment view
// Revision: 1.0 - initial release
// ============================================================================
interface gcd_sched_if
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = GCD_W,
  parameter int IDW   = $clog2(N_REQ)
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] opa;
  logic [N_REQ*W-1:0] opb;
  logic [N_REQ-1:0]   gnt;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_gcd;
  logic               busy;
  logic               eng_rst;
  logic               eng_start;
  logic [W-1:0]       eng_data;
  logic               eng_done;
  logic [W-1:0]       eng_a;

  modport slave (
    input  req, opa, opb, rsp_ready, eng_done, eng_a,
    output gnt, rsp_valid, rsp_id, rsp_gcd, busy, eng_rst, eng_start, eng_data
  );

  modport master (
    output req, opa, opb, rsp_ready, eng_done, eng_a,
    input  gnt, rsp_valid, rsp_id, rsp_gcd, busy, eng_rst, eng_start, eng_data
  );

endinterface
`default_nettype wire

// File: rtl/gcd_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : gcd_rr_arb
// Purpose : Round-robin arbiter. Searches req starting at the pointer
//           (last winner + 1) and reports the first set requester.
// Ports   : clk, rst_n - clock, asynchronous active-low reset
//           req_i      - request vector
//           en_i       - arbitration enable (grant allowed this cycle)
//           gnt_o      - one-hot grant, zero when disabled or no request
//           idx_o      - binary index of the selected requester
// Revision: 1.0 - initial release
// ============================================================================
module gcd_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   idx_o
);

  localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] cand;
  logic           found;

  // Priority search with wrap-around; the pointer always stays below N_REQ,
  // so a single subtraction is enough to wrap the candidate index.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (int'(ptr_q) + k >= N_REQ) begin
        cand = IDW'(int'(ptr_q) + k - N_REQ);
      end else begin
        cand = IDW'(int'(ptr_q) + k);
      end
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (en_i && found) begin
      gnt_o = ONE_HOT_0 << idx_o;
      ptr_d = (int'(idx_o) == N_REQ - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gcd_sched.sv
`default_nettype none
// ============================================================================
// Module  : gcd_sched
// Purpose : Shares one gcd_top engine among N_REQ requesters. Grants
//           round-robin, captures the winner's operands, drives the engine's
//           serial load (start, A, B), waits for done, returns the result
//           tagged with the requester ID and restarts the engine with a
//           one-cycle reset pulse. Zero operands bypass the engine.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           bus   - gcd_sched_if slave modport (requesters, response,
//                   engine control)
// Revision: 1.0 - initial release
// ============================================================================
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = GCD_W,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic        clk,
  input  logic        rst_n,
  gcd_sched_if.slave  bus
);

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   a_q;
  logic [W-1:0]   a_d;
  logic [W-1:0]   b_q;
  logic [W-1:0]   b_d;
  logic [W-1:0]   gcd_q;
  logic [W-1:0]   gcd_d;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] id_d;
  logic           eng_rst_q;

  logic             arb_en;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic [W-1:0]     eng_data;

  // eng_rst_q is high during reset and the first cycle afterwards, and in
  // IDLE it is otherwise low; gating with it keeps grants off while the
  // engine is still being cleared after reset.
  assign arb_en = (state_q == S_IDLE) && !eng_rst_q;

  gcd_rr_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (bus.req),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign sel_a = bus.opa[int'(arb_idx) * W +: W];
  assign sel_b = bus.opb[int'(arb_idx) * W +: W];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    gcd_d    = gcd_q;
    id_d     = id_q;
    eng_data = '0;
    case (state_q)
      S_IDLE: begin
        if (|arb_gnt) begin
          a_d  = sel_a;
          b_d  = sel_b;
          id_d = arb_idx;
          // The engine never terminates on a zero operand: answer directly.
          if (sel_a == '0 || sel_b == '0) begin
            gcd_d   = sel_a | sel_b;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START:  state_d = S_LOAD_A;
      S_LOAD_A: begin
        eng_data = a_q;
        state_d  = S_LOAD_B;
      end
      S_LOAD_B: begin
        eng_data = b_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          gcd_d   = bus.eng_a;
          state_d = S_CLEAR;
        end
      end
      // The engine's DONE state is terminal; eng_rst pulses here.
      S_CLEAR:  state_d = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      gcd_q     <= '0;
      id_q      <= '0;
      eng_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      gcd_q     <= gcd_d;
      id_q      <= id_d;
      eng_rst_q <= (state_d == S_CLEAR);
    end
  end

  assign bus.gnt       = arb_gnt;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_gcd   = gcd_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.eng_rst   = eng_rst_q;
  assign bus.eng_start = (state_q == S_START);
  assign bus.eng_data  = eng_data;

endmodule
`default_nettype wire

// File: tb/tb_gcd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_gcd_sched
// Purpose : Self-checking bench for gcd_sched with a behavioural gcd_top
//           engine (start, load A, load B, compare/subtract loop, terminal
//           DONE) and a response scoreboard.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_gcd_sched;

  localparam int N_REQ = 4;
  localparam int W     = 16;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    int          lat;
  } job_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gcd_sched_if #(.N_REQ(N_REQ), .W(W)) bus ();

  gcd_sched #(.N_REQ(N_REQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural engine ----------------
  typedef enum logic [2:0] {E_IDLE, E_LA, E_LB, E_CMP, E_SUB, E_DONE} est_t;
  est_t        e_st;
  logic [15:0] ea;
  logic [15:0] eb;

  always @(posedge clk) begin
    if (bus.eng_rst) begin
      e_st <= E_IDLE;
      ea   <= '0;
      eb   <= '0;
    end else begin
      case (e_st)
        E_IDLE: if (bus.eng_start) e_st <= E_LA;
        E_LA:   begin ea <= bus.eng_data; e_st <= E_LB; end
        E_LB:   begin eb <= bus.eng_data; e_st <= E_CMP; end
        E_CMP:  e_st <= (ea == eb) ? E_DONE : E_SUB;
        E_SUB:  begin
          if (ea > eb) ea <= ea - eb;
          else         eb <= eb - ea;
          e_st <= E_CMP;
        end
        default: e_st <= E_DONE;
      endcase
    end
  end

  assign bus.eng_done = (e_st == E_DONE);
  assign bus.eng_a    = ea;

  // ---------------- reference model ----------------
  function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    if (a == 0 || b == 0) return a | b;
    x = a; y = b;
    while (x != y) begin
      if (x > y) x = x - y; else y = y - x;
    end
    return x;
  endfunction

  function automatic int lat_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    int n;
    if (a == 0 || b == 0) return 1;
    x = a; y = b; n = 0;
    while (x != y) begin
      if (x > y) x = x - y; else y = y - x;
      n++;
    end
    return 7 + 2 * n;
  endfunction

  function automatic job_t mk_job(input int id, input logic [15:0] a, input logic [15:0] b);
    job_t j;
    j.id = id; j.a = a; j.b = b; j.g = gcd_ref(a, b); j.lat = lat_ref(a, b);
    return j;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ---------------- scoreboard / monitor ----------------
  job_t exp_q[$];
  job_t cur;
  bit   active;
  bit   seen_valid;
  int   cyc, gcyc, vcyc, st_cnt, rs_cnt, rs_rel;

  initial begin
    cyc = 0; active = 0; seen_valid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active     = 0;
        seen_valid = 0;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
      end else begin
        if (active) begin
          int  rel;
          bit  byp;
          rel = cyc - gcyc;
          byp = (cur.a == 0 || cur.b == 0);
          if (bus.eng_start) st_cnt++;
          if (bus.eng_rst) begin rs_cnt++; rs_rel = rel; end
          if (!byp && rel == 1) chk("eng_start_c1", bus.eng_start, 1);
          if (!byp && rel == 2) chk("eng_data_a", bus.eng_data, cur.a);
          if (!byp && rel == 3) chk("eng_data_b", bus.eng_data, cur.b);
          if (bus.rsp_valid && !seen_valid) begin seen_valid = 1; vcyc = cyc; end
          if (bus.rsp_valid && bus.rsp_ready) begin
            chk("rsp_id", bus.rsp_id, cur.id);
            chk("rsp_gcd", bus.rsp_gcd, cur.g);
            chk("latency", vcyc - gcyc, cur.lat);
            chk("eng_start_cnt", st_cnt, byp ? 0 : 1);
            chk("eng_rst_cnt", rs_cnt, byp ? 0 : 1);
            if (!byp) chk("eng_rst_cycle", rs_rel, cur.lat - 1);
            void'(exp_q.pop_front());
            active = 0;
          end
        end else if (bus.rsp_valid) begin
          chk("unexpected_rsp", bus.rsp_valid, 0);
        end
        if (|bus.gnt) begin
          chk("gnt_onehot", $onehot(bus.gnt), 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_gnt", bus.gnt, 0);
          end else if (active) begin
            chk("gnt_while_busy", bus.gnt, 0);
          end else begin
            chk("gnt_index", bus.gnt, 32'd1 << exp_q[0].id);
            cur        = exp_q[0];
            active     = 1;
            gcyc       = cyc;
            st_cnt     = 0;
            rs_cnt     = 0;
            rs_rel     = -1;
            seen_valid = 0;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_gnt(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (|bus.gnt) seen = 1;
    end
    if (!seen) fail_timeout(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_timeout(tag);
      exp_q.delete();
    end
  endtask

  task automatic set_ops(input int id, input logic [15:0] a, input logic [15:0] b);
    bus.opa[id*W +: W] = a;
    bus.opb[id*W +: W] = b;
  endtask

  // ---------------- stimulus ----------------
  job_t        vec[10];
  int          last_win;
  logic [15:0] b2b_a[3];
  logic [15:0] b2b_b[3];

  initial begin
    checks = 0; failures = 0;
    vec[0] = '{0, 16'd12,    16'd8,     16'd4,     11};
    vec[1] = '{1, 16'd0,     16'd9,     16'd9,     1};
    vec[2] = '{2, 16'd0,     16'd0,     16'd0,     1};
    vec[3] = '{3, 16'd48,    16'd18,    16'd6,     15};
    vec[4] = '{0, 16'd17,    16'd5,     16'd1,     19};
    vec[5] = '{1, 16'd65535, 16'd65535, 16'd65535, 7};
    vec[6] = '{2, 16'd65535, 16'd21845, 16'd21845, 11};
    vec[7] = '{2, 16'd40,    16'd1,     16'd1,     85};
    vec[8] = '{1, 16'd7,     16'd0,     16'd7,     1};
    vec[9] = '{3, 16'd21,    16'd14,    16'd7,     11};

    rst_n = 1'b0;
    bus.req = '0; bus.opa = '0; bus.opb = '0; bus.rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_gcd", bus.rsp_gcd, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_eng_data", bus.eng_data, 0);
    chk("rst_eng_rst", bus.eng_rst, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("eng_rst_first_cycle", bus.eng_rst, 1);
    @(negedge clk); chk("eng_rst_released", bus.eng_rst, 0);

    // Table-driven single jobs
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_ops(vec[i].id, vec[i].a, vec[i].b);
      bus.req[vec[i].id] = 1'b1;
      exp_q.push_back(vec[i]);
      wait_gnt("vec_gnt");
      @(posedge clk); #1 bus.req[vec[i].id] = 1'b0;
      wait_idle("vec_done");
      last_win = vec[i].id;
    end

    // Contention: all requesters held, round-robin order from last winner
    @(posedge clk); #1;
    set_ops(0, 16'd48, 16'd18);
    set_ops(1, 16'd17, 16'd5);
    set_ops(2, 16'd65535, 16'd65535);
    set_ops(3, 16'd65535, 16'd21845);
    for (int k = 0; k < 5; k++) begin
      int id;
      id = (last_win + 1 + k) % N_REQ;
      exp_q.push_back(mk_job(id, bus.opa[id*W +: W], bus.opb[id*W +: W]));
    end
    last_win = (last_win + 5) % N_REQ;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_gnt("rr_gnt");
    @(posedge clk); #1 bus.req = '0;
    wait_idle("rr_done");

    // Backpressure: response held, pending request not granted
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_ops(1, 16'd17, 16'd5);
    exp_q.push_back(mk_job(1, 16'd17, 16'd5));
    bus.req[1] = 1'b1;
    wait_gnt("bp_gnt");
    @(posedge clk); #1;
    bus.req[1] = 1'b0;
    set_ops(3, 16'd0, 16'd5);
    exp_q.push_back(mk_job(3, 16'd0, 16'd5));
    bus.req[3] = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (bus.rsp_valid) seen = 1;
      end
      if (!seen) fail_timeout("bp_rsp_valid");
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold", (bus.rsp_valid && bus.rsp_id == 1 && bus.rsp_gcd == 1 && bus.gnt == 0), 1);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk); chk("bp_no_gnt_on_ready", bus.gnt, 0);
    @(negedge clk); chk("bp_next_gnt", bus.gnt, 4'b1000);
    @(posedge clk); #1 bus.req[3] = 1'b0;
    wait_idle("bp_done");
    last_win = 3;

    // Reset during WAIT, requester 2 keeps its request
    @(posedge clk); #1;
    set_ops(2, 16'd48, 16'd18);
    exp_q.push_back(mk_job(2, 16'd48, 16'd18));
    bus.req[2] = 1'b1;
    wait_gnt("mid_gnt");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_eng_rst", bus.eng_rst, 1);
    chk("mid_rst_busy", bus.busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_gnt", bus.gnt, 0);
    end
    exp_q.push_back(mk_job(2, 16'd48, 16'd18));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_eng_rst", bus.eng_rst, 1);
    chk("rel_no_gnt", bus.gnt, 0);
    wait_gnt("rel_gnt");
    @(posedge clk); #1 bus.req[2] = 1'b0;
    wait_idle("rel_done");

    // Back-to-back jobs on requester 1 with changing operands
    b2b_a[0] = 16'd30;  b2b_b[0] = 16'd12;
    b2b_a[1] = 16'd9;   b2b_b[1] = 16'd0;
    b2b_a[2] = 16'd100; b2b_b[2] = 16'd75;
    @(posedge clk); #1;
    set_ops(1, b2b_a[0], b2b_b[0]);
    exp_q.push_back(mk_job(1, b2b_a[0], b2b_b[0]));
    bus.req[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_gnt("b2b_gnt");
      @(posedge clk); #1;
      if (k < 2) begin
        set_ops(1, b2b_a[k+1], b2b_b[k+1]);
        exp_q.push_back(mk_job(1, b2b_a[k+1], b2b_b[k+1]));
      end else begin
        bus.req[1] = 1'b0;
      end
    end
    wait_idle("b2b_done");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
